// File: rtl/nn_mem_pkg.sv
// rtl/nn_mem_pkg.sv - shared memory geometry and reader FSM states
package nn_mem_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 16384;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small synchronous FIFO with flop-held head word and occupancy count
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Storage is reset so the head reads zero while empty after reset.
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  // Pointer, storage and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - credit-limited burst reader turning memory reads into a valid/ready stream
module mem_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  import nn_mem_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [LEN_W-1:0]  issue_rem;
  logic [LEN_W-1:0]  deliver_rem;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_ok;
  logic              cmd_fire;
  logic              push;
  logic              pop;

  // A read is only launched when the word it returns is sure to find a free slot;
  // a pop in the same cycle is deliberately not counted as freeing space.
  assign credit_ok = (fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign push      = mem_valid & inflight;
  assign pop       = out_valid & out_ready;
  assign out_valid = (fifo_count != '0);
  assign out_last  = out_valid & (deliver_rem == LEN_W'(1));
  assign mem_addr  = mem_rd_en ? issue_addr : last_addr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_rd_en = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_fire) state_nxt = (cmd_len == '0) ? DONE : RUN;
      end
      RUN: begin
        mem_rd_en = (issue_rem != '0) && credit_ok;
        if (mem_rd_en && (issue_rem == LEN_W'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue/deliver counters, address generator and in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_rem   <= '0;
      deliver_rem <= '0;
      issue_addr  <= '0;
      last_addr   <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      if (cmd_fire) begin
        issue_rem   <= cmd_len;
        deliver_rem <= cmd_len;
        issue_addr  <= cmd_base;
      end else begin
        if (mem_rd_en) begin
          issue_rem  <= issue_rem - 1'b1;
          issue_addr <= issue_addr + 1'b1;
          last_addr  <= issue_addr;
        end
        if (pop && (deliver_rem != '0)) deliver_rem <= deliver_rem - 1'b1;
      end
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (mem_data),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - directed self-checking bench for mem_stream_reader
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [13:0] cmd_base = '0;
  logic [14:0] cmd_len = '0;
  logic        mem_rd_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  int          ov_cyc_q[$];
  int          done_cyc_q[$];
  logic [31:0] hs_data_q[$];
  logic        hs_last_q[$];
  int          stab_n = 0;
  int          stab_bad = 0;
  logic        pv_stall = 1'b0;
  logic [31:0] pv_data = '0;
  logic        pv_last = 1'b0;

  logic [13:0] t2_addr [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

  mem_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [13:0] a);
    return 32'hC0DE_0000 ^ {a, 4'h5, a};
  endfunction

  // Preloaded 1-cycle-latency memory.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data  <= '0;
      mem_valid <= 1'b0;
    end else begin
      mem_valid <= mem_rd_en;
      if (mem_rd_en) mem_data <= word(mem_addr);
    end
  end

  always @(posedge clk) cyc++;

  // Passive monitor: log reads, stream handshakes, done pulses, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      pv_stall = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_addr_q.push_back(int'(mem_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (out_valid) ov_cyc_q.push_back(cyc);
      if (out_valid && out_ready) begin
        hs_data_q.push_back(out_data);
        hs_last_q.push_back(out_last);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (pv_stall) begin
        stab_n++;
        if (!(out_valid && out_data == pv_data && out_last == pv_last)) stab_bad++;
      end
      pv_stall = out_valid && !out_ready;
      pv_data  = out_data;
      pv_last  = out_last;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [13:0] b, input logic [14:0] l, output int c);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_base  = b;
    cmd_len   = l;
    @(negedge clk);
    c = cyc;
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_cyc_q.size() == d0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cyc_q.size() > d0, 1);
  endtask

  initial begin
    int c, a0, h0, d0, o0, s0, sb0;
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Burst of 8 from 0x0010 with free-running consumer
    a0 = rd_addr_q.size(); h0 = hs_data_q.size(); d0 = done_cyc_q.size(); o0 = ov_cyc_q.size();
    send_cmd(14'h0010, 15'd8, c);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_cmd_ready_busy", cmd_ready, 0);
    wait_done(d0, 100);
    @(negedge clk);
    chk("t1_cmd_ready_back", cmd_ready, 1);
    chk("t1_rd_count", rd_addr_q.size() - a0, 8);
    for (int i = 0; i < 8 && a0 + i < rd_addr_q.size(); i++) begin
      chk("t1_addr", rd_addr_q[a0 + i], 32'h10 + i);
      chk("t1_rd_cyc", rd_cyc_q[a0 + i], c + 1 + i);
    end
    chk("t1_word_count", hs_data_q.size() - h0, 8);
    for (int i = 0; i < 8 && h0 + i < hs_data_q.size(); i++) begin
      chk("t1_data", hs_data_q[h0 + i], word(14'(16 + i)));
      chk("t1_last", hs_last_q[h0 + i], (i == 7) ? 1 : 0);
    end
    chk("t1_ov_count", ov_cyc_q.size() - o0, 8);
    chk("t1_first_ov", (ov_cyc_q.size() > o0) ? ov_cyc_q[o0] : -1, c + 3);
    chk("t1_done_cyc", (done_cyc_q.size() > d0) ? done_cyc_q[d0] : -1, c + 11);

    // Address wrap at the top of memory
    a0 = rd_addr_q.size(); h0 = hs_data_q.size(); d0 = done_cyc_q.size();
    send_cmd(14'h3FFE, 15'd4, c);
    wait_done(d0, 100);
    @(negedge clk);
    chk("t2_rd_count", rd_addr_q.size() - a0, 4);
    for (int i = 0; i < 4 && a0 + i < rd_addr_q.size(); i++)
      chk("t2_addr", rd_addr_q[a0 + i], 32'(t2_addr[i]));
    chk("t2_word_count", hs_data_q.size() - h0, 4);
    for (int i = 0; i < 4 && h0 + i < hs_data_q.size(); i++) begin
      chk("t2_data", hs_data_q[h0 + i], word(t2_addr[i]));
      chk("t2_last", hs_last_q[h0 + i], (i == 3) ? 1 : 0);
    end

    // Stalled consumer: credit limit caps reads at FIFO depth
    a0 = rd_addr_q.size(); h0 = hs_data_q.size(); d0 = done_cyc_q.size();
    out_ready = 1'b0;
    send_cmd(14'h0200, 15'd16, c);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_stall_reads", rd_addr_q.size() - a0, 4);
    chk("t3_stall_valid", out_valid, 1);
    chk("t3_stall_words", hs_data_q.size() - h0, 0);
    out_ready = 1'b1;
    wait_done(d0, 200);
    @(negedge clk);
    chk("t3_rd_count", rd_addr_q.size() - a0, 16);
    chk("t3_word_count", hs_data_q.size() - h0, 16);
    for (int i = 0; i < 16 && h0 + i < hs_data_q.size(); i++) begin
      chk("t3_data", hs_data_q[h0 + i], word(14'(32'h200 + i)));
      chk("t3_last", hs_last_q[h0 + i], (i == 15) ? 1 : 0);
    end

    // Random backpressure over 100 words
    a0 = rd_addr_q.size(); h0 = hs_data_q.size(); d0 = done_cyc_q.size();
    s0 = stab_n; sb0 = stab_bad;
    send_cmd(14'h1234, 15'd100, c);
    n = 0;
    while (done_cyc_q.size() == d0 && n < 3000) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("t4_done_seen", done_cyc_q.size() > d0, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_word_count", hs_data_q.size() - h0, 100);
    for (int i = 0; i < 100 && h0 + i < hs_data_q.size(); i++) begin
      chk("t4_data", hs_data_q[h0 + i], word(14'(32'h1234 + i)));
      chk("t4_last", hs_last_q[h0 + i], (i == 99) ? 1 : 0);
    end
    chk("t4_rd_count", rd_addr_q.size() - a0, 100);
    chk("t4_stall_seen", (stab_n - s0) > 0, 1);
    chk("t4_stall_stable", stab_bad - sb0, 0);
    chk("t4_one_done", done_cyc_q.size() - d0, 1);

    // Zero-length command
    a0 = rd_addr_q.size(); d0 = done_cyc_q.size(); o0 = ov_cyc_q.size();
    send_cmd(14'h0055, 15'd0, c);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_done_count", done_cyc_q.size() - d0, 1);
    chk("t5_done_cyc", (done_cyc_q.size() > d0) ? done_cyc_q[d0] : -1, c + 1);
    chk("t5_no_reads", rd_addr_q.size() - a0, 0);
    chk("t5_no_valid", ov_cyc_q.size() - o0, 0);
    chk("t5_idle", cmd_ready, 1);

    // Reset mid-burst after 5 of 10 words, then a clean command
    h0 = hs_data_q.size();
    send_cmd(14'h0400, 15'd10, c);
    n = 0;
    while (hs_data_q.size() < h0 + 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("t6_five_words", hs_data_q.size() - h0, 5);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_cmd_ready", cmd_ready, 0);
    chk("t6_rst_rd_en", mem_rd_en, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_out_last", out_last, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    h0 = hs_data_q.size(); d0 = done_cyc_q.size();
    send_cmd(14'h0100, 15'd2, c);
    wait_done(d0, 100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_word_count", hs_data_q.size() - h0, 2);
    for (int i = 0; i < 2 && h0 + i < hs_data_q.size(); i++) begin
      chk("t6_data", hs_data_q[h0 + i], word(14'(32'h100 + i)));
      chk("t6_last", hs_last_q[h0 + i], (i == 1) ? 1 : 0);
    end
    chk("t6_done_cyc", (done_cyc_q.size() > d0) ? done_cyc_q[d0] : -1, c + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Burst read sequencer that sits directly downstream of the 16K×32 weight/activation memory (`memory_512kb`). It accepts a command consisting of a base address and a word count. It issues one-per-cycle reads to the memory's 1-cycle-latency read port and buffers the returned words in a small FIFO. The words are presented to the MAC datapath as a valid/ready stream with a last flag. Reads are credit-limited by FIFO space, so downstream backpressure never drops data.

## Interface
- `ADDR_W`, 14, memory word-address width (16384 locations)
- `DATA_W`, 32, memory word width
- `LEN_W`, 15, command length width (0..16384 words)
- `FIFO_DEPTH`, 4, return-buffer depth (power of two, ≥2)

- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: high only in IDLE
- `cmd_base` in ADDR_W: first word address
- `cmd_len` in LEN_W: number of words to read
- `mem_rd_en` out 1: read strobe to memory `rd_en`
- `mem_addr` out ADDR_W: to memory `addr`
- `mem_data` in DATA_W: from memory `data_out`
- `mem_valid` in 1: from memory `valid_out`; asserted the cycle after `mem_rd_en`
- `out_valid` out 1: stream word available
- `out_ready` in 1: consumer accepts
- `out_data` out DATA_W: stream word
- `out_last` out 1: qualifies final word of the command
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse at command completion

## Operation
- FSM states:
  - IDLE → RUN when `cmd_valid & cmd_ready`. Latch base, len, and remaining-to-issue = len, remaining-to-deliver = len. If len = 0, go IDLE → DONE instead.
  - RUN: issue a read whenever issue-remaining > 0 and `fifo_count + inflight < FIFO_DEPTH`. `inflight` is the read issued last cycle, 0 or 1. Same-cycle pop is not credited (conservative).
  - RUN → DRAIN when the final read is issued.
  - DRAIN → DONE on the output handshake of the word with `out_last`.
  - DONE: `done` = 1 for one cycle, then → IDLE.
- Address: `mem_addr` = base + issued_count, modulo 2^ADDR_W. A burst crossing 16383 wraps to 0. `mem_addr` holds its last value when `mem_rd_en` = 0.
- Return path: every `mem_valid` cycle pushes `mem_data` into the FIFO. The credit rule guarantees no overflow. A `mem_valid` with no read in flight is ignored.
- `out_last` = 1 when the head word is the final word of the command (deliver-remaining = 1).
- `cmd_valid` in any state other than IDLE is not accepted. Commands do not queue.
- Reset at any time: FIFO flushed, counters cleared, FSM → IDLE. Any in-flight return is discarded; the memory is reset by the same `rst`.
- Reset values: `cmd_ready` = 0 during reset and 1 after; `mem_rd_en` = 0, `mem_addr` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `busy` = 0, `done` = 0.

## Timing
- Command handshake at cycle C: first `mem_rd_en` at C+1 (addr = base), `mem_valid` at C+2, `out_valid` at C+3. Latency is 3 cycles.
- With `out_ready` held high: one word per cycle sustained. N words occupy `out_valid` for cycles C+3..C+N+2. `done` is at C+N+3, and `cmd_ready` is back at C+N+4.
- Output follows valid/ready: `out_data`/`out_last` are stable while `out_valid & ~out_ready`, and `out_valid` is never withdrawn before the handshake.
- With `out_ready` low, reads stop once fifo_count + inflight = FIFO_DEPTH. At most FIFO_DEPTH words are buffered.
- len = 0: handshake at C, `done` at C+1, no `mem_rd_en`, no `out_valid`.

## Structure
- Shared package `nn_mem_pkg`: `ADDR_W`, `DATA_W`, `MEM_WORDS` = 16384, and the FSM state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: `stream_fifo`, a synchronous FIFO (DEPTH, WIDTH) with push, pop, registered head output, and a count output. It is reused by other streaming stages.
- The top level holds the FSM, issue/deliver counters, address generator, and credit check.

## Test plan
- base = 0x0010, len = 8, `out_ready` = 1: addresses 0x0010..0x0017 on consecutive cycles, and 8 words in order with `out_last` on the 8th. `out_valid` first at C+3, `done` at C+11.
- base = 0x3FFE, len = 4: addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001, and data matches preloaded memory.
- len = 16, `out_ready` low for 20 cycles then high: exactly FIFO_DEPTH = 4 reads are issued while stalled. No word is lost or duplicated, and the order is preserved.
- Random `out_ready` toggling over len = 100: the scoreboard matches all 100 words, `out_data` is stable under stall, and there is one `done` pulse.
- len = 0: `done` pulses at C+1, with no `mem_rd_en` and no `out_valid`.
- `rst` asserted mid-burst after 5 of 10 words: all outputs return to reset values immediately. A new command (base = 0x0100, len = 2) then completes normally with no stale words.
